// File: rtl/decryption_fsm.sv
// Control FSM for the AES-128 inverse cipher datapath: forward key expansion to
// the final round key, then initial AddRoundKey, nine inverse mid rounds and an inverse last round.
package fsm_dec_pkg;
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    KEY_EXPAND    = 3'd1,
    INITIAL_ROUND = 3'd2,
    MID_ROUND     = 3'd3,
    LAST_ROUND    = 3'd4
  } dec_state_e;
endpackage

module decryption_fsm
  import fsm_dec_pkg::*;
#(
  parameter int NR                = 10,
  parameter int MID_ROUND_CYCLES  = 3,
  parameter int LAST_ROUND_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       load_data,
  output logic       key_step,
  output logic       key_dir,
  output logic [3:0] round_key_idx,
  output logic       inv_sub_shift_en,
  output logic       add_key_en,
  output logic       inv_mix_en,
  output logic [3:0] round_count,
  output logic [1:0] round_cycle_count,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] KEY_END  = 4'(NR - 1);
  localparam logic [3:0] MID_END  = 4'(MID_ROUND_CYCLES - 1);
  localparam logic [3:0] LAST_END = 4'(LAST_ROUND_CYCLES - 1);
  localparam logic [3:0] MID_LAST = 4'(NR - 1);

  dec_state_e state;
  logic [3:0] cyc;

  // Handshake: start is a request sampled only while busy=0 (IDLE); the cycle it is
  // sampled high, load_data pulses and the run begins. No deassertion is needed to re-arm.
  assign load_data         = start && (state == IDLE);
  assign busy              = (state != IDLE);
  assign round_cycle_count = cyc[1:0];

  // Each branch sets the registered enables that belong to the cycle being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cyc              <= 4'd0;
      round_count      <= 4'd0;
      round_key_idx    <= 4'd0;
      key_step         <= 1'b0;
      key_dir          <= 1'b0;
      inv_sub_shift_en <= 1'b0;
      add_key_en       <= 1'b0;
      inv_mix_en       <= 1'b0;
      done             <= 1'b0;
    end else begin
      done             <= 1'b0;
      key_step         <= 1'b0;
      key_dir          <= 1'b0;
      inv_sub_shift_en <= 1'b0;
      add_key_en       <= 1'b0;
      inv_mix_en       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= KEY_EXPAND;
            cyc           <= 4'd0;
            round_count   <= 4'd0;
            round_key_idx <= 4'd0;
            key_step      <= 1'b1;
          end
        end
        KEY_EXPAND: begin
          round_key_idx <= round_key_idx + 4'd1;
          if (cyc == KEY_END) begin
            state      <= INITIAL_ROUND;
            cyc        <= 4'd0;
            add_key_en <= 1'b1;
          end else begin
            cyc      <= cyc + 4'd1;
            key_step <= 1'b1;
          end
        end
        INITIAL_ROUND: begin
          state            <= MID_ROUND;
          round_count      <= 4'd1;
          cyc              <= 4'd0;
          inv_sub_shift_en <= 1'b1;
          key_step         <= 1'b1;
          key_dir          <= 1'b1;
        end
        MID_ROUND: begin
          if (cyc == MID_END) begin
            cyc              <= 4'd0;
            round_count      <= round_count + 4'd1;
            inv_sub_shift_en <= 1'b1;
            key_step         <= 1'b1;
            key_dir          <= 1'b1;
            if (round_count == MID_LAST) begin
              state <= LAST_ROUND;
            end
          end else begin
            cyc <= cyc + 4'd1;
            if (cyc == 4'd0) begin
              // Inverse key step issued this cycle lands before the AddRoundKey cycle.
              round_key_idx <= round_key_idx - 4'd1;
              add_key_en    <= 1'b1;
            end else begin
              inv_mix_en <= 1'b1;
            end
          end
        end
        LAST_ROUND: begin
          if (cyc == LAST_END) begin
            state       <= IDLE;
            cyc         <= 4'd0;
            round_count <= 4'd0;
            done        <= 1'b1;
          end else begin
            cyc           <= cyc + 4'd1;
            round_key_idx <= round_key_idx - 4'd1;
            add_key_en    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cyc   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_fsm.sv
// Bench for decryption_fsm: a position-in-run model (0 = idle, 1..40 = run cycle)
// predicts every output each cycle; table vectors and directed sequences drive it.
module tb_decryption_fsm;
  import fsm_dec_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic       load_data;
  logic       key_step;
  logic       key_dir;
  logic [3:0] round_key_idx;
  logic       inv_sub_shift_en;
  logic       add_key_en;
  logic       inv_mix_en;
  logic [3:0] round_count;
  logic [1:0] round_cycle_count;
  logic       busy;
  logic       done;

  decryption_fsm dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .load_data         (load_data),
    .key_step          (key_step),
    .key_dir           (key_dir),
    .round_key_idx     (round_key_idx),
    .inv_sub_shift_en  (inv_sub_shift_en),
    .add_key_en        (add_key_en),
    .inv_mix_en        (inv_mix_en),
    .round_count       (round_count),
    .round_cycle_count (round_cycle_count),
    .busy              (busy),
    .done              (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;     // model position: 0 idle, 1..40 cycles of a run
  logic exp_done = 1'b0;
  int cyc_num   = 0;
  int start_cyc = 0;
  int cnt_fwd, cnt_inv, cnt_mix, cnt_add, cnt_sub;
  int done_seen = 0;
  int both_seen = 0;

  typedef struct {
    dec_state_e st;
    logic ks, kd, ss, ak, mx, bz;
    int idx, rc, cc;
  } exp_t;

  function automatic exp_t model(int p);
    exp_t e;
    int m, r;
    e = '{st: IDLE, ks: 0, kd: 0, ss: 0, ak: 0, mx: 0, bz: 0, idx: 0, rc: 0, cc: 0};
    if (p >= 1 && p <= 10) begin
      e.st = KEY_EXPAND; e.ks = 1; e.idx = p - 1; e.cc = (p - 1) % 4;
    end else if (p == 11) begin
      e.st = INITIAL_ROUND; e.ak = 1; e.idx = 10;
    end else if (p >= 12 && p <= 38) begin
      m = p - 12; r = m / 3 + 1;
      e.st = MID_ROUND; e.rc = r; e.cc = m % 3;
      e.idx = (e.cc == 0) ? 11 - r : 10 - r;
      if (e.cc == 0) begin e.ss = 1; e.ks = 1; e.kd = 1; end
      else if (e.cc == 1) e.ak = 1;
      else e.mx = 1;
    end else if (p == 39 || p == 40) begin
      e.st = LAST_ROUND; e.rc = 10; e.cc = p - 39;
      e.idx = (p == 39) ? 1 : 0;
      if (p == 39) begin e.ss = 1; e.ks = 1; e.kd = 1; end
      else e.ak = 1;
    end
    e.bz = (p != 0);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (pos=%0d cycle=%0d)", name, act, expv, pos, cyc_num);
    end
  endtask

  // Compare all outputs against the model; called at the falling edge.
  task automatic check_outputs();
    exp_t e;
    e = model(pos);
    chk("state", int'(dut.state), int'(e.st));
    chk("load_data", int'(load_data), int'(start && pos == 0));
    chk("key_step", int'(key_step), int'(e.ks));
    if (e.ks) chk("key_dir", int'(key_dir), int'(e.kd));
    chk("inv_sub_shift_en", int'(inv_sub_shift_en), int'(e.ss));
    chk("add_key_en", int'(add_key_en), int'(e.ak));
    chk("inv_mix_en", int'(inv_mix_en), int'(e.mx));
    chk("round_key_idx", int'(round_key_idx), e.idx);
    chk("round_count", int'(round_count), e.rc);
    chk("round_cycle_count", int'(round_cycle_count), e.cc);
    chk("busy", int'(busy), int'(e.bz));
    chk("done", int'(done), int'(exp_done));
    chk("enable_onehot", int'(inv_sub_shift_en + add_key_en + inv_mix_en <= 2'd1), 1);
    if (done === 1'b1) done_seen++;
    if (done === 1'b1 && load_data === 1'b1) both_seen++;
    if (exp_done) begin
      chk("latency", cyc_num - start_cyc, 41);
      chk("cnt_key_fwd", cnt_fwd, 10);
      chk("cnt_key_inv", cnt_inv, 10);
      chk("cnt_inv_mix", cnt_mix, 9);
      chk("cnt_add_key", cnt_add, 11);
      chk("cnt_inv_sub", cnt_sub, 10);
    end
    if (key_step === 1'b1 && key_dir === 1'b0) cnt_fwd++;
    if (key_step === 1'b1 && key_dir === 1'b1) cnt_inv++;
    if (inv_mix_en === 1'b1) cnt_mix++;
    if (add_key_en === 1'b1) cnt_add++;
    if (inv_sub_shift_en === 1'b1) cnt_sub++;
  endtask

  // Model update for the rising edge that ends the current cycle.
  task automatic advance(input logic r, input logic s);
    exp_done = 1'b0;
    if (r) begin
      pos = 0;
    end else if (pos == 0) begin
      if (s) begin
        pos = 1; start_cyc = cyc_num;
        cnt_fwd = 0; cnt_inv = 0; cnt_mix = 0; cnt_add = 0; cnt_sub = 0;
      end
    end else if (pos == 40) begin
      pos = 0; exp_done = 1'b1;
    end else begin
      pos++;
    end
    cyc_num++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic s);
    reset = r; start = s;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance(r, s);
    #1;
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (pos != target && n < 100) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk("run_to_bound", int'(pos == target), 1);
  endtask

  typedef struct {
    logic r, s;
    logic e_busy, e_done, e_load;
    logic [3:0] e_idx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int d0;
    vecs[0] = '{r: 1, s: 0, e_busy: 0, e_done: 0, e_load: 0, e_idx: 0};
    vecs[1] = '{r: 0, s: 0, e_busy: 0, e_done: 0, e_load: 0, e_idx: 0};
    vecs[2] = '{r: 0, s: 1, e_busy: 0, e_done: 0, e_load: 1, e_idx: 0};
    vecs[3] = '{r: 0, s: 0, e_busy: 1, e_done: 0, e_load: 0, e_idx: 0};
    vecs[4] = '{r: 0, s: 0, e_busy: 1, e_done: 0, e_load: 0, e_idx: 1};
    vecs[5] = '{r: 0, s: 1, e_busy: 1, e_done: 0, e_load: 0, e_idx: 2};
    vecs[6] = '{r: 0, s: 0, e_busy: 1, e_done: 0, e_load: 0, e_idx: 3};
    vecs[7] = '{r: 0, s: 0, e_busy: 1, e_done: 0, e_load: 0, e_idx: 4};

    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    cyc_num = 1;

    // Table vectors: reset tail, idle, start, early key expansion with ignored start.
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].r; start = vecs[i].s;
      @(negedge clk);
      check_outputs();
      chk("vec_busy", int'(busy), int'(vecs[i].e_busy));
      chk("vec_done", int'(done), int'(vecs[i].e_done));
      chk("vec_load", int'(load_data), int'(vecs[i].e_load));
      chk("vec_idx", int'(round_key_idx), int'(vecs[i].e_idx));
      @(posedge clk);
      advance(vecs[i].r, vecs[i].s);
      #1;
    end
    d0 = done_seen;
    run_to(0);
    cycle(1'b0, 1'b0);
    chk("first_run_done", done_seen - d0, 1);

    // Busy-ignore: start pulse in mid round 4 (pos 21).
    cycle(1'b0, 1'b1);
    run_to(21);
    cycle(1'b0, 1'b1);
    d0 = done_seen;
    run_to(0);
    cycle(1'b0, 1'b0);
    chk("busy_ignore_done", done_seen - d0, 1);

    // Back-to-back: start held high for two full runs.
    d0 = done_seen;
    both_seen = 0;
    for (int i = 0; i < 90; i++) cycle(1'b0, 1'b1);
    chk("b2b_done_count", done_seen - d0, 2);
    chk("b2b_done_and_load", both_seen, 2);
    run_to(0);
    cycle(1'b0, 1'b0);

    // Reset in mid round 5, cycle 1 (pos 25); no done afterwards.
    cycle(1'b0, 1'b1);
    run_to(25);
    cycle(1'b1, 1'b0);
    d0 = done_seen;
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0);
    chk("reset_no_done", done_seen - d0, 0);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 45; i++) cycle(1'b0, 1'b0);
    chk("after_reset_run_done", done_seen - d0, 1);

    // Random stimulus: sparse start, rare reset (never together with start).
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) cycle(1'b1, 1'b0);
      else cycle(1'b0, 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decryption_fsm.md
Name: decryption_fsm

Overview:
- Control FSM for the AES-128 inverse cipher datapath; it is the decrypt-side counterpart of encryption_fsm.
- It first runs the key schedule forward to obtain the final round key. It then sequences the initial AddRoundKey, nine 3-cycle inverse mid rounds and a 2-cycle inverse last round. Round keys are consumed in reverse order via inverse key-schedule steps.
- It drives datapath enables only; it touches no data.

Parameters:
- NR, 10, number of cipher rounds; only 10 is supported, and the KEY_EXPAND length equals NR.
- MID_ROUND_CYCLES, 3, cycles per mid round.
- LAST_ROUND_CYCLES, 2, cycles in the last round.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to decrypt; sampled only in IDLE.
- load_data  out  1  one-cycle pulse that loads ciphertext and cipher key into the datapath.
- key_step  out  1  advance the key schedule by one step.
- key_dir  out  1  key-schedule direction: 0 = forward, 1 = inverse; valid when key_step=1.
- round_key_idx  out  4  index of the round key currently held in the key register (0..NR).
- inv_sub_shift_en  out  1  enable for InvShiftRows+InvSubBytes.
- add_key_en  out  1  enable for AddRoundKey.
- inv_mix_en  out  1  enable for InvMixColumns.
- round_count  out  4  current round number.
- round_cycle_count  out  2  cycle index within the current phase.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: plaintext is valid.

Behaviour:
- States are IDLE, KEY_EXPAND, INITIAL_ROUND, MID_ROUND and LAST_ROUND, encoded as enum dec_state_e in package fsm_dec_pkg. The state register is named state.
- Reset, taking priority over everything: state=IDLE; every output and counter is 0; a pending done is cancelled. Reset in any state returns to IDLE on the next edge, with no done.
- IDLE:
  - load_data is combinational: load_data = start && state==IDLE.
  - An edge with start=1 moves to KEY_EXPAND, with round_cycle_count=0 and round_key_idx=0.
  - start=0 stays in IDLE.
- KEY_EXPAND, NR cycles:
  - key_step=1 and key_dir=0 every cycle.
  - round_cycle_count counts 0..NR-1 (4-bit internal counter; the port shows the low 2 bits).
  - round_key_idx increments at every edge in this state, reaching NR on exit.
  - After NR cycles: go to INITIAL_ROUND.
- INITIAL_ROUND, 1 cycle:
  - add_key_en=1 using key NR; round_count=0.
  - Then go to MID_ROUND with round_count=1 and round_cycle_count=0.
- MID_ROUND, rounds 1..NR-1, MID_ROUND_CYCLES cycles each:
  - Cycle 0: inv_sub_shift_en=1, key_step=1, key_dir=1. round_key_idx decrements at the edge that ends this cycle.
  - Cycle 1: add_key_en=1, using key NR-round_count.
  - Cycle 2: inv_mix_en=1.
  - At the end of cycle 2: round_count increments and round_cycle_count wraps to 0.
  - After round NR-1 cycle 2: go to LAST_ROUND with round_count=NR.
  - Total MID_ROUND occupancy is 27 cycles.
- LAST_ROUND, LAST_ROUND_CYCLES cycles:
  - Cycle 0: inv_sub_shift_en=1, key_step=1, key_dir=1; round_key_idx goes to 0.
  - Cycle 1: add_key_en=1 using key 0. The edge ending this cycle returns to IDLE and registers done=1.
- done is high only during the first IDLE cycle after LAST_ROUND. round_count and round_cycle_count are 0 in IDLE.
- Latency: the edge sampling start is edge 0. State sequence: KEY_EXPAND for cycles 1..10, INITIAL_ROUND for cycle 11, MID_ROUND for cycles 12..38, LAST_ROUND for cycles 39..40, IDLE with done=1 in cycle 41.
- Back-to-back: start=1 in the done cycle is accepted, so load_data and done are both high in that cycle.
- start is ignored while busy=1; it needs no deassertion to re-arm.
- At most one of inv_sub_shift_en, add_key_en and inv_mix_en is high in any cycle. key_step is never high in IDLE or INITIAL_ROUND.

Test Plan:
- Reset: reset=1 for 2 cycles, then start=1 one cycle later -> IDLE, all outputs 0 before start. After start: KEY_EXPAND x10, INITIAL_ROUND x1, MID_ROUND x27, LAST_ROUND x2, IDLE with done=1 for exactly one cycle.
- Key indexing: one full run -> round_key_idx=10 in INITIAL_ROUND. In MID round r cycle 1, add_key_en=1 with idx=10-r. idx=0 in LAST cycle 1. key_step with key_dir=0 occurs exactly 10 times and with key_dir=1 exactly 10 times.
- Enable sequencing: check the one-hot enable pattern per cycle across the whole run. inv_mix_en occurs exactly 9 times, add_key_en exactly 11 times, inv_sub_shift_en exactly 10 times.
- Busy-ignore and back-to-back: pulse start in MID round 4 -> no effect, and done arrives at cycle 41 of the first run. Hold start=1 continuously -> done and load_data coincide, and the second run's done is 41 cycles later.
- Reset mid-operation: assert reset in MID_ROUND round 5 cycle 1 -> next cycle IDLE, all outputs 0, no done ever. A following start completes a normal 41-cycle run.
